// File: rtl/ddr3_port_arbiter.sv
// Two-client round-robin arbiter for the single DDR3 master port, one transaction
// in flight, per-client base offset and completion timeout with error reporting.
module ddr3_port_arbiter #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 128,
  parameter logic [ADDR_W-1:0] BASE0          = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE1          = 32'h0010_0000,
  parameter int unsigned       TIMEOUT_CYCLES = 4096,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic              c0_err,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic              c1_err,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] sdram_address,
  output logic              rd_en,
  output logic              wr_en,
  output logic [DATA_W-1:0] write_data_input,
  input  logic [DATA_W-1:0] read_data,
  input  logic              write_complete,
  input  logic              read_complete,
  output logic              busy,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              tflag_q, tflag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic sel;
  logic done_ok;
  logic timed_out;

  // On a tie the client that did not win last time gets the port.
  assign sel       = (c0_req & c1_req) ? ~last_q : c1_req;
  assign done_ok   = we_q ? write_complete : read_complete;
  assign timed_out = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    last_d   = last_q;
    err_d    = err_q;
    tflag_d  = tflag_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (c0_req | c1_req) begin
          owner_d = sel;
          we_d    = sel ? c1_we : c0_we;
          addr_d  = sel ? (BASE1 + c1_addr) : (BASE0 + c0_addr);
          wdata_d = sel ? c1_wdata : c0_wdata;
          last_d  = sel;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A completion that coincides with the timeout still counts as success.
        if (done_ok) begin
          state_d = ACK;
          if (!we_q) begin
            if (owner_q) rdata1_d = read_data;
            else         rdata0_d = read_data;
          end
        end else if (timed_out) begin
          state_d = ACK;
          err_d   = 1'b1;
          tflag_d = 1'b1;
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      tflag_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      last_q   <= last_d;
      err_q    <= err_d;
      tflag_q  <= tflag_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign rd_en            = (state_q == BUSY) & ~we_q;
  assign wr_en            = (state_q == BUSY) & we_q;
  assign sdram_address    = addr_q;
  assign write_data_input = wdata_q;
  assign c0_ack           = (state_q == ACK) & ~owner_q;
  assign c1_ack           = (state_q == ACK) & owner_q;
  assign c0_err           = c0_ack & err_q;
  assign c1_err           = c1_ack & err_q;
  assign c0_rdata         = rdata0_q;
  assign c1_rdata         = rdata1_q;
  assign timeout_flag     = tflag_q;

endmodule
